seg_display_arbiter: RTL and testbench
======================================

Name: seg_display_arbiter

Overview:
- Shares the single 4-digit seven-segment display between four requesters, e.g. the CPU result register, the memory address, a debug probe and a status word.
- Runs a round-robin arbiter with a valid/ready handshake. It captures the winner's 16-bit word and holds it on the display for a fixed dwell time, then re-arbitrates.
- Keeps a sticky error flag that forces the "Err" pattern.
- Drives the hex/error inputs of the seven_segment driver directly.

Parameters:
- DwellCycles, 50_000_000, clock cycles a captured word stays on the display before re-arbitration (0.5 s at 100 MHz). Legal range is 1 to 2^32-1.
- NumReq, 4, number of requesters. Fixed at 4; the parameter exists for documentation only and no other value is supported.

Ports:
- clk  input  1  100 MHz system clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  4  per-requester valid; bit i belongs to requester i
- req_data  input  64  per-requester word; requester i uses bits [16*i+15:16*i]
- req_ready  output  4  one-hot grant; a transfer happens on a rising edge where req_valid[i] and req_ready[i] are both high
- err_set  input  1  pulse that sets the sticky error flag
- err_clear  input  1  pulse that clears the sticky error flag
- hex  output  16  word to display, to seven_segment.hex
- error  output  1  sticky error flag, to seven_segment.error
- owner  output  2  index of the requester whose word is currently displayed
- shown  output  1  high once any word has been captured since reset

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: hex=16'h0000, error=0, owner=0, shown=0, req_ready=0.
  - Internal: state=ARB, dwell counter=0, round-robin pointer last=3, so requester 0 has top priority first.
  - Reset mid-dwell abandons the dwell immediately. No transfer occurs on a reset cycle.
- States: ARB and DWELL.
- ARB:
  - req_ready is combinational: a one-hot on the first i with req_valid[i]=1, searched in order last+1, last+2, last+3, last (mod 4).
  - req_ready is all-zero if no valid is high, or if rst is high.
  - On a clock edge with a grant:
    - hex <= req_data slice of the winner.
    - owner <= winner, last <= winner, shown <= 1.
    - dwell counter <= DwellCycles-1, state <= DWELL.
  - With no valid, the state stays ARB and hex/owner hold their last values (no blanking).
- DWELL:
  - req_ready=0 for all requesters.
  - The counter decrements each cycle. In the cycle it reads 0, the state goes to ARB.
  - The word is therefore on hex for exactly DwellCycles cycles before the first cycle in which a new grant can occur.
  - With DwellCycles=1, DWELL lasts one cycle, so back-to-back grants are 2 cycles apart.
- Handshake rules:
  - A requester must hold valid and data stable until it sees ready. Dropping valid before the grant is legal and simply forfeits that turn.
  - The arbiter never grants a requester whose valid is low in the grant cycle.
  - Data is sampled only on the transfer edge.
- Fairness:
  - With all four valid continuously, grants go in the order 0,1,2,3,0,...
  - A single continuous requester is re-granted after every dwell.
- Error flag:
  - error is registered.
  - err_set=1 makes error 1 on the next cycle. err_clear=1 alone makes it 0 on the next cycle.
  - If both are high in the same cycle, set wins.
  - Arbitration, capture and hex updates continue while error=1; the seven_segment driver shows "Err" until the flag clears, then shows the current hex immediately.
- Widths:
  - Dwell counter is 32 bits unsigned with no wrap; it is reloaded only on grant.
  - The pointer arithmetic is 2-bit modulo-4.
- Outputs change only on clock edges, except req_ready, which is combinational from state, last and req_valid.

Test Plan (DwellCycles=4 for simulation):
1. Reset/idle:
   - Stimulus: assert rst 3 cycles, then hold all req_valid=0 for 20 cycles.
   - Required: hex=0000, error=0, shown=0, req_ready=0 throughout.
2. Single grant and dwell:
   - Stimulus: req_valid=4'b0100 with slice 2=16'hBEEF held high.
   - Required: req_ready=4'b0100 in the first ARB cycle. On the next edge hex=BEEF, owner=2, shown=1.
   - Required: req_ready stays 0 for exactly 4 cycles, then req_ready=4'b0100 again.
3. Round-robin:
   - Stimulus: all valid held high; slices 0..3 = 1111/2222/3333/4444.
   - Required: grant order 0,1,2,3,0; hex sequence 1111,2222,3333,4444,1111; grants 5 cycles apart.
4. Valid withdrawn:
   - Stimulus: req_valid=4'b0011 and last=0; requester 1 drops valid in the same cycle the dwell ends.
   - Required: req_ready=4'b0001; requester 0 is granted and requester 1 gets no transfer.
5. Error flag:
   - Stimulus: err_set pulse, then a grant of 16'hCAFE, then err_set and err_clear together, then err_clear alone.
   - Required: error=1 one cycle after the set; hex=CAFE while error=1; error stays 1 after the simultaneous pulse; error=0 after the clear alone.
6. Reset mid-dwell:
   - Stimulus: assert rst 2 cycles into DWELL with req_valid=4'b1000.
   - Required: next cycle hex=0000, shown=0, req_ready=0 while rst is high; in the first cycle after rst deasserts, req_ready=4'b1000.

Source files
------------

// File: rtl/seg_display_arbiter.sv
// Round-robin sharing of one 4-digit seven-segment display between four requesters.
// Latency: a grant is combinational in ARB; the captured word appears on hex one edge later.
// Backpressure: req_ready stays low through the dwell period, and while no requester is valid.
module seg_display_arbiter #(
  parameter int unsigned DwellCycles = 50_000_000,
  parameter int unsigned NumReq      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NumReq-1:0]        req_valid,
  input  logic [16*NumReq-1:0]     req_data,
  output logic [NumReq-1:0]        req_ready,
  input  logic                     err_set,
  input  logic                     err_clear,
  output logic [15:0]              hex,
  output logic                     error,
  output logic [1:0]               owner,
  output logic                     shown
);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_DWELL = 1'b1
  } state_e;

  // The counter is loaded with DwellCycles-1 so that it reads zero in the last dwell cycle.
  localparam logic [31:0] DwellLoad = 32'(DwellCycles - 32'd1);

  state_e      state_q;
  logic [31:0] cnt_q;
  logic [1:0]  last_q;
  logic [15:0] hex_q;
  logic [1:0]  owner_q;
  logic        shown_q;
  logic        error_q;

  logic        grant_vld;
  logic [1:0]  win_idx;
  logic [1:0]  cand;

  // Round-robin search starting just after the last winner, wrapping back to it.
  always_comb begin
    grant_vld = 1'b0;
    win_idx   = last_q;
    cand      = 2'd0;
    req_ready = '0;
    if (state_q == ST_ARB && !rst) begin
      for (int k = 1; k <= 4; k++) begin
        cand = last_q + 2'(k);
        if (!grant_vld && req_valid[cand]) begin
          grant_vld = 1'b1;
          win_idx   = cand;
        end
      end
    end
    if (grant_vld) begin
      req_ready[win_idx] = 1'b1;
    end
  end

  // Arbitration/dwell FSM, captured word and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARB;
      cnt_q   <= 32'd0;
      last_q  <= 2'd3;
      hex_q   <= 16'h0000;
      owner_q <= 2'd0;
      shown_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      // Set has priority over clear when both pulse together.
      if (err_set) begin
        error_q <= 1'b1;
      end else if (err_clear) begin
        error_q <= 1'b0;
      end

      case (state_q)
        ST_ARB: begin
          if (grant_vld) begin
            hex_q   <= req_data[{win_idx, 4'b0000} +: 16];
            owner_q <= win_idx;
            last_q  <= win_idx;
            shown_q <= 1'b1;
            cnt_q   <= DwellLoad;
            state_q <= ST_DWELL;
          end
        end
        ST_DWELL: begin
          if (cnt_q == 32'd0) begin
            state_q <= ST_ARB;
          end else begin
            cnt_q <= cnt_q - 32'd1;
          end
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  assign hex   = hex_q;
  assign owner = owner_q;
  assign shown = shown_q;
  assign error = error_q;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Directed bench for seg_display_arbiter with a short dwell time.
// Expected transfers are queued as they are set up and checked when the DUT takes them.
// All expected values come from the bench's own knowledge of the stimulus.
module tb_seg_display_arbiter;

  localparam int unsigned Dwell = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [63:0] req_data;
  logic [3:0]  req_ready;
  logic        err_set;
  logic        err_clear;
  logic [15:0] hex;
  logic        error;
  logic [1:0]  owner;
  logic        shown;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] data;
  } sb_t;

  sb_t sb[$];
  int  tests;
  int  failed;

  seg_display_arbiter #(
    .DwellCycles(Dwell),
    .NumReq     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_data (req_data),
    .req_ready(req_ready),
    .err_set  (err_set),
    .err_clear(err_clear),
    .hex      (hex),
    .error    (error),
    .owner    (owner),
    .shown    (shown)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // Advance one clock; if a transfer was offered this cycle, pop and check it.
  task automatic step();
    logic [3:0] xfer;
    sb_t        e;
    #1;
    xfer = req_valid & req_ready;
    @(posedge clk);
    #1;
    if (xfer != 4'b0000) begin
      tests++;
      assert (sb.size() > 0) else begin
        failed++;
        $error("FAIL sb_unexpected: observed transfer %b expected none", xfer);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_grant", 64'(xfer), 64'(4'b0001 << e.idx));
        chk("sb_word", 64'({owner, hex, shown}), 64'({e.idx, e.data, 1'b1}));
      end
    end
  endtask

  task automatic expect_grant(input string tag, input int idx, input logic [15:0] data);
    sb_t e;
    settle();
    chk(tag, 64'(req_ready), 64'(4'b0001 << idx));
    e.idx  = 2'(idx);
    e.data = data;
    sb.push_back(e);
    step();
  endtask

  task automatic expect_dwell(input string tag);
    for (int d = 0; d < int'(Dwell); d++) begin
      settle();
      chk(tag, 64'(req_ready), 64'd0);
      step();
    end
  endtask

  initial begin
    tests     = 0;
    failed    = 0;
    rst       = 1'b1;
    req_valid = 4'b0000;
    req_data  = 64'd0;
    err_set   = 1'b0;
    err_clear = 1'b0;

    // 1. Reset then idle.
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("rst_ready", 64'(req_ready), 64'd0);
      step();
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      settle();
      chk("idle_state", 64'({hex, error, shown, owner, req_ready}), 64'd0);
      step();
    end

    // 2. Single requester: grant, dwell, re-grant.
    req_data[32 +: 16] = 16'hBEEF;
    req_valid          = 4'b0100;
    expect_grant("single_ready", 2, 16'hBEEF);
    expect_dwell("single_dwell");
    expect_grant("single_regrant", 2, 16'hBEEF);
    expect_dwell("single_dwell2");

    // 3. Round robin from a fresh reset (last=3).
    rst = 1'b1;
    step();
    rst       = 1'b0;
    req_data  = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      expect_grant("rr_ready", g % 4, 16'(17'h1111 * ((g % 4) + 1)));
      if (g == 4) req_valid = 4'b0011;
      expect_dwell("rr_dwell");
    end

    // 4. Requester 1 withdraws as the dwell ends; last=0 would otherwise favour it.
    req_valid         = 4'b0001;
    req_data[0 +: 16] = 16'h5555;
    expect_grant("withdraw_ready", 0, 16'h5555);

    // 5. Sticky error flag.
    err_set            = 1'b1;
    req_valid          = 4'b0010;
    req_data[16 +: 16] = 16'hCAFE;
    step();
    err_set = 1'b0;
    chk("err_after_set", 64'(error), 64'd1);
    for (int i = 0; i < int'(Dwell) - 1; i++) begin
      settle();
      chk("err_dwell_ready", 64'({error, req_ready}), 64'({1'b1, 4'b0000}));
      step();
    end
    expect_grant("err_grant", 1, 16'hCAFE);
    req_valid = 4'b0000;
    chk("err_hex_held", 64'({error, hex}), 64'({1'b1, 16'hCAFE}));
    err_set   = 1'b1;
    err_clear = 1'b1;
    step();
    err_set   = 1'b0;
    err_clear = 1'b0;
    chk("err_both", 64'(error), 64'd1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("err_clear", 64'({error, hex}), 64'({1'b0, 16'hCAFE}));

    // 6. Reset two cycles into a dwell.
    req_valid = 4'b1000;
    step();
    step();
    expect_grant("rd_grant", 3, 16'h4444);
    step();
    step();
    rst = 1'b1;
    settle();
    chk("rd_ready_rst", 64'(req_ready), 64'd0);
    step();
    chk("rd_cleared", 64'({hex, shown, owner, req_ready}), 64'd0);
    settle();
    chk("rd_ready_rst2", 64'(req_ready), 64'd0);
    step();
    rst = 1'b0;
    expect_grant("rd_after_rst", 3, 16'h4444);
    req_valid = 4'b0000;
    step();

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
